// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver for one FRAME_BITS-wide frame, LSB first.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and the stop bit.
module uart_rx_frame #(
   parameter int unsigned FRAME_BITS = 160,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sample_tick,
   input  logic                  rx_in,
   input  logic                  rd_enable,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rx_busy,
   output logic                  frame_err,
   output logic                  overrun
);
   localparam int unsigned      TickW    = $clog2(OVERSAMPLE);
   localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
   localparam logic [7:0]       BitLast  = 8'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e                state_q, state_d;
   logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
   logic [7:0]            bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
   logic                  rx_meta_q, rx_s_q;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rx_busy_q, rx_busy_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q, overrun_d;
   logic                  parity_ok, stop_good, stop_bad;

`ifdef UART_RX_PARITY_EN
   logic parity_q, parity_d;
   assign parity_ok = ~(^{shift_q, parity_q});
`else
   assign parity_ok = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
`ifdef UART_RX_PARITY_EN
      parity_d   = parity_q;
`endif
      stop_good  = 1'b0;
      stop_bad   = 1'b0;
      if (sample_tick) begin
         case (state_q)
            StIdle: begin
               if (!rx_s_q) begin
                  state_d    = StStart;
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
               end
            end
            StStart: begin
               if (tick_cnt_q == TickMid) begin
                  // A line that is high again at mid-start was a glitch, not a frame.
                  state_d    = rx_s_q ? StIdle : StData;
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            StData: begin
               if (tick_cnt_q == TickLast) begin
                  tick_cnt_d         = '0;
                  shift_d[bit_cnt_q] = rx_s_q;
                  if (bit_cnt_q == BitLast) begin
                     bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                     state_d   = StParity;
`else
                     state_d   = StStop;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + 8'd1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (tick_cnt_q == TickLast) begin
                  parity_d   = rx_s_q;
                  state_d    = StStop;
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
`endif
            StStop: begin
               if (tick_cnt_q == TickLast) begin
                  // Leave mid-stop so the next start edge can be caught.
                  state_d    = StIdle;
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  if (rx_s_q && parity_ok) begin
                     stop_good = 1'b1;
                  end else begin
                     stop_bad = 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      // Completion beats a same-cycle read: the new frame is unread.
      rx_data_d   = stop_good ? shift_q : rx_data_q;
      rx_valid_d  = stop_good | (rx_valid_q & ~rd_enable);
      overrun_d   = (stop_good & rx_valid_q & ~rd_enable) | (overrun_q & ~rd_enable);
      frame_err_d = stop_bad | (frame_err_q & ~rd_enable);
      rx_busy_d   = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= StIdle;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_busy_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q   <= rx_in;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_busy_q   <= rx_busy_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_busy   = rx_busy_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: random-gap tick stream, bit-level serial driver and a
// frame-level reference model of the receive flags.
module tb_uart_rx_frame;
   localparam int unsigned FrameBits  = 160;
   localparam int unsigned Oversample = 16;
   // Start is seen on tick 1 of the start bit (synchronizer lag), mid-bit is Oversample/2 later.
   localparam int          DoneTick   = Oversample / 2 + 1;
   localparam logic [FrameBits-1:0] FrameKnown =
      160'h0123_4567_89AB_CDEF_0011_2233_4455_6677_8899_AABB;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 sample_tick;
   logic                 rx_in;
   logic                 rd_enable;
   logic [FrameBits-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_busy;
   logic                 frame_err;
   logic                 overrun;

   int n_vec;
   int n_err;

   logic [FrameBits-1:0] m_data;
   logic                 m_valid, m_err, m_ovr;

   always #5 clk = ~clk;

   uart_rx_frame #(
      .FRAME_BITS(FrameBits),
      .OVERSAMPLE(Oversample)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sample_tick(sample_tick),
      .rx_in      (rx_in),
      .rd_enable  (rd_enable),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   task automatic check_val(input string tag, input logic [FrameBits-1:0] got,
                            input logic [FrameBits-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic busy_exp);
      check_val({tag, ".rx_data"}, rx_data, m_data);
      check_val({tag, ".rx_valid"}, rx_valid, m_valid);
      check_val({tag, ".frame_err"}, frame_err, m_err);
      check_val({tag, ".overrun"}, overrun, m_ovr);
      check_val({tag, ".rx_busy"}, rx_busy, busy_exp);
   endtask

   // Reference model: what the consumer should see once a whole frame has been decided.
   task automatic model_reset();
      m_data  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_read();
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_frame(input logic [FrameBits-1:0] d, input bit good, input bit rd);
      if (good) begin
         m_ovr   = (m_ovr && !rd) || (m_valid && !rd);
         m_err   = m_err && !rd;
         m_data  = d;
         m_valid = 1'b1;
      end else begin
         m_ovr   = m_ovr && !rd;
         m_valid = m_valid && !rd;
         m_err   = 1'b1;
      end
   endtask

   function automatic logic [FrameBits-1:0] rand_frame();
      logic [FrameBits-1:0] d;
      for (int i = 0; i < FrameBits; i++) d[i] = 1'($urandom_range(0, 1));
      return d;
   endfunction

   // One sample_tick strobe followed by 1..2 idle clocks.
   task automatic tick_once(input bit rd);
      sample_tick = 1'b1;
      rd_enable   = rd;
      @(negedge clk);
      sample_tick = 1'b0;
      rd_enable   = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
   endtask

   task automatic send_bit(input bit b, input int rd_tick);
      rx_in = b;
      for (int t = 0; t < Oversample; t++) tick_once(t == rd_tick);
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1, -1);
   endtask

   task automatic read_pulse();
      rd_enable = 1'b1;
      @(negedge clk);
      rd_enable = 1'b0;
      model_read();
   endtask

   task automatic send_frame(input logic [FrameBits-1:0] d, input bit stop_val,
                             input bit par_flip, input bit rd_on_done);
      send_bit(1'b0, -1);
      for (int i = 0; i < FrameBits; i++) send_bit(d[i], -1);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip, -1);
`endif
      send_bit(stop_val, rd_on_done ? DoneTick : -1);
      model_frame(d, stop_val && !par_flip, rd_on_done);
   endtask

   initial begin
      logic [FrameBits-1:0] fa;
      logic [FrameBits-1:0] fb;
      n_vec       = 0;
      n_err       = 0;
      reset       = 1'b1;
      rx_in       = 1'b1;
      sample_tick = 1'b0;
      rd_enable   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset", 1'b0);
      reset = 1'b0;
      idle_bits(1);

      send_frame(FrameKnown, 1'b1, 1'b0, 1'b0);
      idle_bits(1);
      check_outputs("known_frame", 1'b0);
      read_pulse();
      check_outputs("read_known", 1'b0);

      // Glitch: five low ticks abort at mid-start.
      rx_in = 1'b0;
      repeat (3) tick_once(1'b0);
      check_val("glitch.busy_mid", rx_busy, 1'b1);
      repeat (2) tick_once(1'b0);
      idle_bits(1);
      check_outputs("glitch", 1'b0);

      send_frame(rand_frame(), 1'b0, 1'b0, 1'b0);
      idle_bits(1);
      check_outputs("bad_stop", 1'b0);
      read_pulse();
      check_outputs("bad_stop_read", 1'b0);

      fa = rand_frame();
      fb = rand_frame();
      send_frame(fa, 1'b1, 1'b0, 1'b0);
      send_frame(fb, 1'b1, 1'b0, 1'b0);
      idle_bits(1);
      check_outputs("b2b_overrun", 1'b0);
      read_pulse();

      fa = rand_frame();
      fb = rand_frame();
      send_frame(fa, 1'b1, 1'b0, 1'b0);
      send_frame(fb, 1'b1, 1'b0, 1'b1);
      idle_bits(1);
      check_outputs("b2b_read_at_done", 1'b0);

      // Abort a frame at data bit 80 with a still-unread frame pending.
      fa = rand_frame();
      send_bit(1'b0, -1);
      for (int i = 0; i < 80; i++) send_bit(fa[i], -1);
      rx_in = fa[80];
      repeat (5) tick_once(1'b0);
      check_val("mid_reset.busy_before", rx_busy, 1'b1);
      reset = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check_outputs("mid_reset", 1'b0);
      idle_bits(1);
      fb = rand_frame();
      send_frame(fb, 1'b1, 1'b0, 1'b0);
      idle_bits(1);
      check_outputs("after_reset_frame", 1'b0);

`ifdef UART_RX_PARITY_EN
      read_pulse();
      send_frame(rand_frame(), 1'b1, 1'b1, 1'b0);
      idle_bits(1);
      check_outputs("parity_bad", 1'b0);
      read_pulse();
      send_frame(rand_frame(), 1'b1, 1'b0, 1'b0);
      idle_bits(1);
      check_outputs("parity_good", 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter FRAME_BITS, default 160: number of data bits per frame, LSB first; legal range 1..255.
REQ-002 Parameter OVERSAMPLE, default 16: sample_tick strobes per bit period; must be even, legal range 4..16.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sample_tick  input  1  one-cycle strobe at OVERSAMPLE x baud rate; all sampling occurs only on cycles where it is 1.
REQ-006 rx_in  input  1  asynchronous serial line; idles high.
REQ-007 rd_enable  input  1  consumer acknowledge; clears rx_valid, overrun and frame_err.
REQ-008 rx_data  output  FRAME_BITS  last good frame; bit i is the i-th received data bit.
REQ-009 rx_valid  output  1  high while rx_data holds an unread frame.
REQ-010 rx_busy  output  1  high in every state except IDLE.
REQ-011 frame_err  output  1  sticky; set when a stop bit (or parity, if enabled) fails.
REQ-012 overrun  output  1  sticky; set when a frame completes while rx_valid=1 and rd_enable=0.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchronizer (rx_s); all decisions use rx_s, adding 2 clk of latency.
REQ-014 States SHALL be IDLE, START, DATA, PARITY (only when RX_PARITY_EN is defined), and STOP.
REQ-015 Tick counter: $clog2(OVERSAMPLE) bits. Bit counter: 8 bits. Both SHALL be zeroed on entry to START, DATA, PARITY and STOP.
REQ-016 IDLE: on a tick with rx_s=0, go to START.
REQ-017 START: on tick count OVERSAMPLE/2-1, if rx_s=0 go to DATA; otherwise treat as a false start and return to IDLE with no flags changed.
REQ-018 DATA: every OVERSAMPLE ticks after the start-bit midpoint, sample rx_s into shift index bit_cnt, then increment bit_cnt.
REQ-019 DATA: after sample FRAME_BITS-1, go to PARITY if enabled, else STOP.
REQ-020 STOP: one bit period after the previous sample, take the stop sample, then return to IDLE on the next cycle (half a bit early, to allow resync).
REQ-021 On a good stop sample (rx_s=1 and parity OK), rx_data SHALL load the shift register and rx_valid SHALL be 1 on the next clk.
REQ-022 On a bad stop sample, rx_data and rx_valid SHALL be left unchanged and frame_err SHALL be set.
REQ-023 rd_enable=1 SHALL clear rx_valid, overrun and frame_err on the next clk.
REQ-024 Completion and rd_enable in the same cycle: rx_valid stays 1, rx_data takes the new frame, and overrun is not set.
REQ-025 Completion with rx_valid=1 and rd_enable=0: rx_data is overwritten, rx_valid stays 1, and overrun is set.
REQ-026 Bad frame and rd_enable in the same cycle: frame_err SHALL end at 1 (set wins).
REQ-027 sample_tick=0 SHALL freeze the FSM and both counters.

Reset
REQ-028 reset=1 at a clk edge SHALL force: state IDLE, counters 0, shift register 0, rx_data 0, rx_valid 0, rx_busy 0, frame_err 0, overrun 0, and both synchronizer flops 1.
REQ-029 Reset mid-frame SHALL discard the partial frame without setting any flag.
REQ-030 Reset SHALL take priority over rd_enable and sample_tick.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the data bits. In PARITY, rx_s is sampled one bit period after the last data sample. A mismatch (XOR of data bits and parity bit = 1) SHALL set frame_err at the stop-sample decision point.
REQ-032 Macro undefined: the PARITY state and logic are absent; a frame is start + FRAME_BITS data + stop.

Verification
REQ-033 Scenario: reset, then one frame with data 160'h0123_4567_89AB_CDEF_0011_2233_4455_6677_8899_AABB at OVERSAMPLE=16 -> rx_valid=1, rx_data matches, frame_err=0, overrun=0.
REQ-034 Scenario: rx_in low for 5 ticks only -> START aborts to IDLE; rx_busy returns to 0; no flags set.
REQ-035 Scenario: frame with stop bit driven 0 -> frame_err=1, rx_valid=0, rx_data unchanged; rd_enable pulse -> frame_err=0.
REQ-036 Scenario: two back-to-back frames (A then B) with no rd_enable -> rx_data=B, overrun=1; rd_enable on the cycle of B's completion instead -> overrun=0.
REQ-037 Scenario: reset asserted at data bit 80, then frame C -> only C is delivered; all outputs 0 immediately after reset.
REQ-038 Scenario (UART_RX_PARITY_EN defined): frame with a wrong parity bit -> frame_err=1, rx_valid=0; frame with correct parity -> rx_valid=1.
